// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data and overflow/underflow error pulses
module sync_fifo #(
  parameter int DEPTH     = 16,
  parameter int WIDTH     = 8,
  parameter int PTR_WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             wr_error_o,
  output logic             full_o,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             rd_error_o
);
  logic [PTR_WIDTH:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic wr_error_q, wr_error_d, rd_error_q, rd_error_d;
  logic wr_ok, rd_ok;
  assign empty_o = wr_ptr_q == rd_ptr_q;
  assign full_o = (wr_ptr_q[PTR_WIDTH] != rd_ptr_q[PTR_WIDTH]) &&
                  (wr_ptr_q[PTR_WIDTH-1:0] == rd_ptr_q[PTR_WIDTH-1:0]);
  assign wr_ok = wr_en_i && !full_o;
  assign rd_ok = rd_en_i && !empty_o;
  always_comb begin
    wr_ptr_d = wr_ok ? wr_ptr_q + (PTR_WIDTH+1)'(1) : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + (PTR_WIDTH+1)'(1) : rd_ptr_q;
    rdata_d = rd_ok ? mem_q[rd_ptr_q[PTR_WIDTH-1:0]] : rdata_q;
    wr_error_d = wr_en_i && full_o;
    rd_error_d = rd_en_i && empty_o;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rdata_q <= '0;
      wr_error_q <= 1'b0;
      rd_error_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rdata_q <= rdata_d;
      wr_error_q <= wr_error_d;
      rd_error_q <= rd_error_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_ok) mem_q[wr_ptr_q[PTR_WIDTH-1:0]] <= wdata_i;
  end
  assign rdata_o = rdata_q;
  assign wr_error_o = wr_error_q;
  assign rd_error_o = rd_error_q;
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed and random stimulus against a queue-based FIFO model
module tb_sync_fifo;
  logic clk = 1'b0;
  logic rst, wr_en, rd_en;
  logic [7:0] wdata, rdata;
  logic wr_error, full, empty, rd_error;
  int total = 0;
  int bad = 0;
  logic [7:0] q[$];
  logic [7:0] exp_rdata = 8'h00;
  logic exp_we = 1'b0;
  logic exp_re = 1'b0;
  sync_fifo #(.DEPTH(16), .WIDTH(8), .PTR_WIDTH(4)) dut (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wdata_i(wdata), .wr_error_o(wr_error),
    .full_o(full), .rd_en_i(rd_en), .rdata_o(rdata), .empty_o(empty), .rd_error_o(rd_error)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic r, input logic w, input logic rd, input logic [7:0] d);
    bit f, e;
    rst = r;
    wr_en = w;
    rd_en = rd;
    wdata = d;
    f = q.size() == 16;
    e = q.size() == 0;
    @(posedge clk);
    if (r) begin
      q.delete();
      exp_rdata = 8'h00;
      exp_we = 1'b0;
      exp_re = 1'b0;
    end else begin
      exp_we = w && f;
      exp_re = rd && e;
      if (rd && !e) exp_rdata = q.pop_front();
      if (w && !f) q.push_back(d);
    end
    #1;
    check("empty", 32'(empty), 32'(q.size() == 0));
    check("full", 32'(full), 32'(q.size() == 16));
    check("rdata", 32'(rdata), 32'(exp_rdata));
    check("wr_error", 32'(wr_error), 32'(exp_we));
    check("rd_error", 32'(rd_error), 32'(exp_re));
  endtask
  initial begin
    logic [7:0] first_byte;
    step(1, 0, 0, 0);
    check("reset_empty", 32'(empty), 1);
    check("reset_rdata", 32'(rdata), 0);
    for (int i = 0; i < 16; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      if (i == 0) first_byte = b;
      step(0, 1, 0, b);
    end
    check("fill_full", 32'(full), 1);
    step(0, 1, 0, 8'hEE);
    check("overflow_err", 32'(wr_error), 1);
    step(0, 0, 1, 0);
    check("drain_first", 32'(rdata), 32'(first_byte));
    for (int i = 1; i < 17; i++) step(0, 0, 1, 0);
    check("underflow_err", 32'(rd_error), 1);
    check("drain_empty", 32'(empty), 1);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 8'($urandom));
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 0, 8'(i));
    check("wrap_full", 32'(full), 1);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1, 0);
      check("wrap_data", 32'(rdata), i);
    end
    step(0, 1, 1, 8'hA5);
    check("sim_empty_rderr", 32'(rd_error), 1);
    check("sim_empty_one", 32'(empty), 0);
    for (int i = 0; i < 15; i++) step(0, 1, 0, 8'($urandom));
    step(0, 1, 1, 8'h3C);
    check("sim_full_wrerr", 32'(wr_error), 1);
    check("sim_full_drop", 32'(full), 0);
    check("sim_full_data", 32'(rdata), 32'h A5);
    for (int i = 0; i < 15; i++) step(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'($urandom));
    step(1, 0, 0, 0);
    check("midrst_empty", 32'(empty), 1);
    step(0, 0, 1, 0);
    check("midrst_rderr", 32'(rd_error), 1);
    for (int p = 0; p < 20; p++) begin
      int wp, rp;
      wp = $urandom_range(10, 90);
      rp = $urandom_range(10, 90);
      for (int i = 0; i < 100; i++)
        step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < wp,
             $urandom_range(0, 99) < rp, 8'($urandom));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
